// File: rtl/can_wb_pkg.sv
// can_wb_pkg: definitions shared by the CAN Wishbone slave bridge and the CAN
// register bank. It holds the bus-side FSM state type and the default address
// and data geometry of the register map.
// Ports: none (package).
package can_wb_pkg;

  // Default register-map geometry. The register bank uses the same values,
  // so both ends agree on what counts as a mapped address.
  localparam int CAN_ADDR_W   = 8;
  localparam int CAN_DATA_W   = 8;
  localparam int CAN_ADDR_MAX = 31;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4
  } wb_state_e;

endpackage

// File: rtl/can_wb_slave.sv
// can_wb_slave: Wishbone classic slave that bridges host cycles onto the CAN
// register bank. A write becomes a one-cycle reg_we_o strobe. A read becomes a
// one-cycle reg_re_o strobe for clear-on-read side effects, then the data is
// captured after READ_LAT extra cycles. Addresses above ADDR_MAX raise
// wb_err_o and never reach the register bank.
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   wb_cyc_i, wb_stb_i     Wishbone cycle and strobe from the host
//   wb_we_i                1 = write, 0 = read
//   wb_adr_i, wb_dat_i     host address and write data
//   wb_dat_o               read data, held until the next read capture
//   wb_ack_o, wb_err_o     one-cycle completion pulses; never high together
//   reg_addr_o             latched address to the register bank
//   reg_wdata_o            latched write data to the register bank
//   reg_we_o, reg_re_o     one-cycle write and read strobes to the register bank
//   reg_rdata_i            read data from the register bank read mux
module can_wb_slave
  import can_wb_pkg::*;
#(
  parameter int ADDR_W   = CAN_ADDR_W,
  parameter int DATA_W   = CAN_DATA_W,
  parameter int ADDR_MAX = CAN_ADDR_MAX,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i
);

  // Read latency counter. $clog2(1) is 0, so keep at least one bit to
  // avoid a zero-width vector when the read mux is combinational.
  localparam int CNT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT);

  wb_state_e         state;
  wb_state_e         state_nxt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              accept;
  logic              unmapped;
  logic              rd_last;

  // A new transfer is accepted only from IDLE. If stb is still high right
  // after ACK or ERR, that is a new transfer, because those states always
  // return to IDLE.
  assign accept   = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign unmapped = (32'(wb_adr_i) > ADDR_MAX);
  assign rd_last  = (rd_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (unmapped) begin
            state_nxt = ERR;
          end else if (wb_we_i) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      // The write strobe is already on the bank port. It completes even if
      // the host drops cyc, but no ack is returned for an abandoned cycle.
      WR:      state_nxt = wb_cyc_i ? ACK : IDLE;
      // Dropping cyc during a read abandons it with no capture and no ack.
      RD: begin
        if (!wb_cyc_i) begin
          state_nxt = IDLE;
        end else if (rd_last) begin
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. This decodes only registered state, so there is no
  // combinational path from wb_* inputs to any output.
  always_comb begin
    reg_we_o = 1'b0;
    reg_re_o = 1'b0;
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    case (state)
      WR:      reg_we_o = 1'b1;
      // The counter still holds its load value only in the first RD cycle,
      // so the clear-on-read side effect fires exactly once per read.
      RD:      reg_re_o = (rd_cnt == CNT_LOAD);
      ACK:     wb_ack_o = 1'b1;
      ERR:     wb_err_o = 1'b1;
      default: ;
    endcase
  end

  // Address and write data latch, read counter and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      rd_cnt      <= '0;
      wb_dat_o    <= '0;
    end else begin
      if (accept) begin
        reg_addr_o  <= wb_adr_i;
        reg_wdata_o <= wb_dat_i;
        rd_cnt      <= CNT_LOAD;
      end else if ((state == RD) && !rd_last) begin
        rd_cnt <= rd_cnt - 1'b1;
      end
      if ((state == RD) && wb_cyc_i && rd_last) begin
        wb_dat_o <= reg_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_can_wb_slave.sv
module tb_can_wb_slave;

  localparam int K_WE  = 0;
  localparam int K_RE  = 1;
  localparam int K_ACK = 2;
  localparam int K_ERR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int compared = 0;
  int mismatched = 0;

  // Three instances: READ_LAT 0, 2 and 3 (index 0, 1, 2).
  logic       rst_s   [3];
  logic       cyc_s   [3];
  logic       stb_s   [3];
  logic       we_s    [3];
  logic [7:0] adr_s   [3];
  logic [7:0] dat_i_s [3];
  logic [7:0] dat_o_s [3];
  logic       ack_s   [3];
  logic       err_s   [3];
  logic [7:0] addr_s  [3];
  logic [7:0] wdata_s [3];
  logic       rwe_s   [3];
  logic       rre_s   [3];
  logic [7:0] rdata_s [3];

  can_wb_slave #(.ADDR_W(8), .DATA_W(8), .ADDR_MAX(31), .READ_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst_s[0]), .wb_cyc_i(cyc_s[0]), .wb_stb_i(stb_s[0]),
    .wb_we_i(we_s[0]), .wb_adr_i(adr_s[0]), .wb_dat_i(dat_i_s[0]),
    .wb_dat_o(dat_o_s[0]), .wb_ack_o(ack_s[0]), .wb_err_o(err_s[0]),
    .reg_addr_o(addr_s[0]), .reg_wdata_o(wdata_s[0]), .reg_we_o(rwe_s[0]),
    .reg_re_o(rre_s[0]), .reg_rdata_i(rdata_s[0]));

  can_wb_slave #(.ADDR_W(8), .DATA_W(8), .ADDR_MAX(31), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst_s[1]), .wb_cyc_i(cyc_s[1]), .wb_stb_i(stb_s[1]),
    .wb_we_i(we_s[1]), .wb_adr_i(adr_s[1]), .wb_dat_i(dat_i_s[1]),
    .wb_dat_o(dat_o_s[1]), .wb_ack_o(ack_s[1]), .wb_err_o(err_s[1]),
    .reg_addr_o(addr_s[1]), .reg_wdata_o(wdata_s[1]), .reg_we_o(rwe_s[1]),
    .reg_re_o(rre_s[1]), .reg_rdata_i(rdata_s[1]));

  can_wb_slave #(.ADDR_W(8), .DATA_W(8), .ADDR_MAX(31), .READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst_s[2]), .wb_cyc_i(cyc_s[2]), .wb_stb_i(stb_s[2]),
    .wb_we_i(we_s[2]), .wb_adr_i(adr_s[2]), .wb_dat_i(dat_i_s[2]),
    .wb_dat_o(dat_o_s[2]), .wb_ack_o(ack_s[2]), .wb_err_o(err_s[2]),
    .reg_addr_o(addr_s[2]), .reg_wdata_o(wdata_s[2]), .reg_we_o(rwe_s[2]),
    .reg_re_o(rre_s[2]), .reg_rdata_i(rdata_s[2]));

  // Register bank model, one per instance: preloaded on the first edge,
  // written by reg_we_o, and read through a combinational mux on reg_addr_o.
  logic [7:0] bank [3][256];
  always @(posedge clk) begin
    if (cyc_n == 0) begin
      for (int d = 0; d < 3; d++) begin
        for (int a = 0; a < 256; a++) bank[d][a] <= 8'(a) ^ 8'hFF;
        bank[d][3] <= 8'h3C;
        bank[d][5] <= 8'h77;
      end
    end else begin
      for (int d = 0; d < 3; d++)
        if (rwe_s[d] === 1'b1) bank[d][addr_s[d]] <= wdata_s[d];
    end
  end
  assign rdata_s[0] = bank[0][addr_s[0]];
  assign rdata_s[1] = bank[1][addr_s[1]];
  assign rdata_s[2] = bank[2][addr_s[2]];

  // Scoreboard of expected strobe events, each with its expected cycle.
  typedef struct {
    int         dut;
    int         kind;
    int         cyc;
    logic [7:0] adr;
    logic [7:0] dat;
    bit         chk;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] exp_dat [3];

  function automatic string kname(input int k);
    case (k)
      K_WE:    return "reg_we";
      K_RE:    return "reg_re";
      K_ACK:   return "ack";
      default: return "err";
    endcase
  endfunction

  function automatic int lat_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  // Monitor: pop and compare an expectation for every strobe the DUTs produce.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc < cyc_n) begin
      compared++;
      mismatched++;
      $display("FAIL missing_%s dut%0d: expected at cycle %0d, not seen by cycle %0d",
               kname(sbq[0].kind), sbq[0].dut, sbq[0].cyc, cyc_n);
      void'(sbq.pop_front());
    end
    for (int d = 0; d < 3; d++) begin
      if (ack_s[d] === 1'b1 && err_s[d] === 1'b1) begin
        compared++;
        mismatched++;
        $display("FAIL ack_err_overlap dut%0d cycle %0d: ack=1 err=1, required at most one", d, cyc_n);
      end
      if (rwe_s[d] === 1'b1 && rre_s[d] === 1'b1) begin
        compared++;
        mismatched++;
        $display("FAIL we_re_overlap dut%0d cycle %0d: we=1 re=1, required at most one", d, cyc_n);
      end
      for (int k = 0; k < 4; k++) begin
        logic ev;
        case (k)
          K_WE:    ev = rwe_s[d];
          K_RE:    ev = rre_s[d];
          K_ACK:   ev = ack_s[d];
          default: ev = err_s[d];
        endcase
        if (ev === 1'b1) begin
          compared++;
          if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_%s dut%0d cycle %0d: got a pulse, required none",
                     kname(k), d, cyc_n);
          end else begin
            exp_t e;
            bit   bad;
            e = sbq.pop_front();
            bad = (e.dut != d) || (e.kind != k) || (e.cyc != cyc_n);
            if (k == K_WE && (addr_s[d] !== e.adr || wdata_s[d] !== e.dat)) bad = 1'b1;
            if ((k == K_RE || k == K_ERR) && addr_s[d] !== e.adr) bad = 1'b1;
            if (e.chk && dat_o_s[d] !== e.dat) bad = 1'b1;
            if (bad) begin
              mismatched++;
              $display("FAIL event_%s: got dut%0d %s cycle %0d addr=%h wdata=%h dat_o=%h; required dut%0d %s cycle %0d addr=%h data=%h",
                       kname(k), d, kname(k), cyc_n, addr_s[d], wdata_s[d], dat_o_s[d],
                       e.dut, kname(e.kind), e.cyc, e.adr, e.dat);
            end
          end
        end
      end
    end
  end

  // Stimulus: drive a transfer just after a rising edge and queue what it must
  // produce. The edge that samples it is E0 = cyc_n + 1.
  task automatic start_xfer(input int d, input bit we, input logic [7:0] adr,
                            input logic [7:0] dat, input bit completes);
    exp_t e;
    int   k;
    cyc_s[d]   = 1'b1;
    stb_s[d]   = 1'b1;
    we_s[d]    = we;
    adr_s[d]   = adr;
    dat_i_s[d] = we ? dat : 8'h00;
    k = cyc_n;
    if (adr > 8'd31) begin
      e = '{d, K_ERR, k + 1, adr, exp_dat[d], 1'b1};
      sbq.push_back(e);
    end else if (we) begin
      e = '{d, K_WE, k + 1, adr, dat, 1'b0};
      sbq.push_back(e);
      if (completes) begin
        e = '{d, K_ACK, k + 2, adr, dat, 1'b0};
        sbq.push_back(e);
      end
    end else begin
      e = '{d, K_RE, k + 1, adr, dat, 1'b0};
      sbq.push_back(e);
      if (completes) begin
        e = '{d, K_ACK, k + 2 + lat_of(d), adr, dat, 1'b1};
        sbq.push_back(e);
        exp_dat[d] = dat;
      end
    end
  endtask

  // Hold the request until ack/err is seen (bounded), then step past that edge.
  task automatic wait_end(input int d, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ack_s[d] === 1'b1 || err_s[d] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout dut%0d: no ack/err within 30 cycles, required one", name, d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus(input int d);
    cyc_s[d] = 1'b0;
    stb_s[d] = 1'b0;
    we_s[d]  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      compared++;
      if ({dat_o_s[d], ack_s[d], err_s[d], addr_s[d], wdata_s[d], rwe_s[d], rre_s[d]} !== 28'h0) begin
        mismatched++;
        $display("FAIL reset_state dut%0d: got dat=%h ack=%b err=%b addr=%h wdata=%h we=%b re=%b, required all 0",
                 d, dat_o_s[d], ack_s[d], err_s[d], addr_s[d], wdata_s[d], rwe_s[d], rre_s[d]);
      end
      exp_dat[d] = 8'h00;
      rst_s[d]   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    start_xfer(0, 1'b1, 8'h04, 8'hA5, 1'b1);
    wait_end(0, "write");
    release_bus(0);
    compared++;
    if (dat_o_s[0] !== 8'h00) begin
      mismatched++;
      $display("FAIL write_dat_o: got %h, required 00", dat_o_s[0]);
    end
  endtask

  task automatic test_read(input int d, input string name);
    start_xfer(d, 1'b0, 8'h03, 8'h3C, 1'b1);
    wait_end(d, name);
    release_bus(d);
    compared++;
    if (dat_o_s[d] !== 8'h3C) begin
      mismatched++;
      $display("FAIL %s_dat_o dut%0d: got %h, required 3c", name, d, dat_o_s[d]);
    end
  endtask

  task automatic test_error();
    start_xfer(0, 1'b1, 8'h20, 8'h99, 1'b1);
    wait_end(0, "err_write");
    release_bus(0);
    start_xfer(0, 1'b0, 8'h20, 8'h00, 1'b1);
    wait_end(0, "err_read");
    release_bus(0);
    compared++;
    if (dat_o_s[0] !== 8'h3C) begin
      mismatched++;
      $display("FAIL err_dat_o_kept: got %h, required 3c", dat_o_s[0]);
    end
  endtask

  task automatic test_back_to_back();
    start_xfer(0, 1'b1, 8'h01, 8'h5A, 1'b1);
    wait_end(0, "b2b_write");
    start_xfer(0, 1'b0, 8'h01, 8'h5A, 1'b1);
    wait_end(0, "b2b_read");
    release_bus(0);
    compared++;
    if (dat_o_s[0] !== 8'h5A) begin
      mismatched++;
      $display("FAIL b2b_read_data: got %h, required 5a", dat_o_s[0]);
    end
  endtask

  task automatic test_abort();
    start_xfer(2, 1'b0, 8'h05, 8'h77, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    release_bus(2);
    @(posedge clk);
    #1;
    start_xfer(2, 1'b1, 8'h07, 8'h11, 1'b1);
    wait_end(2, "post_abort_write");
    release_bus(2);
    compared++;
    if (dat_o_s[2] !== 8'h3C) begin
      mismatched++;
      $display("FAIL abort_dat_o_kept: got %h, required 3c", dat_o_s[2]);
    end
  endtask

  task automatic test_reset_mid_read();
    test_read(1, "lat2_read");
    start_xfer(1, 1'b0, 8'h05, 8'h77, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_s[1] = 1'b1;
    #1;
    compared++;
    if ({dat_o_s[1], ack_s[1], err_s[1], addr_s[1], wdata_s[1], rwe_s[1], rre_s[1]} !== 28'h0) begin
      mismatched++;
      $display("FAIL mid_read_reset: got dat=%h ack=%b err=%b addr=%h wdata=%h we=%b re=%b, required all 0",
               dat_o_s[1], ack_s[1], err_s[1], addr_s[1], wdata_s[1], rwe_s[1], rre_s[1]);
    end
    release_bus(1);
    exp_dat[1] = 8'h00;
    @(posedge clk);
    #1;
    rst_s[1] = 1'b0;
    start_xfer(1, 1'b1, 8'h06, 8'h42, 1'b1);
    wait_end(1, "post_reset_write");
    release_bus(1);
    start_xfer(1, 1'b0, 8'h06, 8'h42, 1'b1);
    wait_end(1, "post_reset_read");
    release_bus(1);
    compared++;
    if (dat_o_s[1] !== 8'h42) begin
      mismatched++;
      $display("FAIL post_reset_read_data: got %h, required 42", dat_o_s[1]);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d]   = 1'b1;
      cyc_s[d]   = 1'b0;
      stb_s[d]   = 1'b0;
      we_s[d]    = 1'b0;
      adr_s[d]   = 8'h00;
      dat_i_s[d] = 8'h00;
      exp_dat[d] = 8'h00;
    end
    test_reset();
    test_write();
    test_read(0, "read_lat0");
    test_read(2, "read_lat3");
    test_error();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();
    repeat (6) @(negedge clk);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drained: got %0d pending events, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
